// File: rtl/traffic_display_if.sv
// traffic_display_if: countdown/lamp inputs and multiplexed segment outputs of the display stage.
interface traffic_display_if;
    logic [7:0] acount;
    logic [7:0] bcount;
    logic [3:0] lampa;
    logic [3:0] lampb;
    logic [7:0] seg;
    logic [3:0] dig_sel;
    modport master (output acount, bcount, lampa, lampb, input seg, dig_sel);
    modport slave (input acount, bcount, lampa, lampb, output seg, dig_sel);
endinterface

// File: rtl/traffic_display.sv
// traffic_display: sequential BCD conversion of the A/B countdowns onto a 4-digit
// multiplexed seven-segment display with yellow blink and left-turn decimal point.
module traffic_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input logic              clk,
    input logic              rst_n,
    traffic_display_if.slave io_disp
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] L_YELLOW = 4'b0010;
    localparam logic [3:0] L_LEFT   = 4'b1000;

    logic [1:0]    r_state;
    logic [2:0]    r_bit;
    logic [7:0]    r_a_bin, r_b_bin;
    logic [11:0]   r_a_bcd, r_b_bcd;
    logic [3:0]    r_a_t, r_a_o, r_b_t, r_b_o;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_dig;
    logic [FW-1:0] r_frame;
    logic          r_blink;
    logic [7:0]    r_seg;
    logic [3:0]    r_dig_sel;
    logic [11:0]   w_a_adj, w_b_adj;
    logic          w_tc;
    logic [3:0]    w_val;
    logic [3:0]    w_lamp;
    logic          w_blank;
    logic          w_dp;
    logic [7:0]    w_seg;

    function automatic logic [11:0] adj3(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++)
            r[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign w_a_adj = adj3(r_a_bcd);
    assign w_b_adj = adj3(r_b_bcd);
    assign w_tc    = r_presc == PW'(SCAN_DIV - 1);
    assign w_val   = r_dig == 2'd0 ? r_a_t : r_dig == 2'd1 ? r_a_o : r_dig == 2'd2 ? r_b_t : r_b_o;
    assign w_lamp  = r_dig[1] ? io_disp.lampb : io_disp.lampa;
    // Tens digits (even slots) blank on zero; a blinking direction blanks dp too
    assign w_blank = (w_lamp == L_YELLOW && r_blink) || (!r_dig[0] && w_val == 4'd0);
    assign w_dp    = r_dig[0] && w_lamp == L_LEFT;
    assign w_seg   = w_blank ? 8'h00 : {w_dp, seg7(w_val)};

    assign io_disp.seg     = r_seg;
    assign io_disp.dig_sel = r_dig_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_t   <= '0;
            r_a_o   <= '0;
            r_b_t   <= '0;
            r_b_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a_bin <= io_disp.acount;
                    r_b_bin <= io_disp.bcount;
                    r_a_bcd <= '0;
                    r_b_bcd <= '0;
                    r_bit   <= '0;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    {r_a_bcd, r_a_bin} <= {w_a_adj[10:0], r_a_bin, 1'b0};
                    {r_b_bcd, r_b_bin} <= {w_b_adj[10:0], r_b_bin, 1'b0};
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_a_t   <= |r_a_bcd[11:8] ? 4'd9 : r_a_bcd[7:4];
                    r_a_o   <= |r_a_bcd[11:8] ? 4'd9 : r_a_bcd[3:0];
                    r_b_t   <= |r_b_bcd[11:8] ? 4'd9 : r_b_bcd[7:4];
                    r_b_o   <= |r_b_bcd[11:8] ? 4'd9 : r_b_bcd[3:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_dig     <= '0;
            r_frame   <= '0;
            r_blink   <= 1'b0;
            r_seg     <= 8'h00;
            r_dig_sel <= 4'hF;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc) r_dig <= r_dig + 2'd1;
            if (w_tc && r_dig == 2'd3) begin
                if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
            r_seg     <= w_seg;
            r_dig_sel <= ~(4'b0001 << r_dig);
        end
    end
endmodule

// File: tb/tb_traffic_display.sv
// tb_traffic_display: vector table of count/lamp combinations checked over full scan
// frames, plus hand-timed reset, latency and blink sequences.
module tb_traffic_display;
    localparam int SD = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    int   ecount = 0;

    traffic_display_if dif ();

    traffic_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_disp(dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  la;
        logic [3:0]  lb;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[10];

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic run_to(input int e);
        while (ecount < e) tick();
    endtask

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [3:0] la, input logic [3:0] lb);
        dif.acount = a;
        dif.bcount = b;
        dif.lampa  = la;
        dif.lampb  = lb;
    endtask

    task automatic chk(input string nm, input logic [7:0] s, input logic [3:0] d);
        n_run++;
        if (dif.seg !== s || dif.dig_sel !== d) begin
            n_fail++;
            $display("FAIL %s: seg=%h dig_sel=%b, expected seg=%h dig_sel=%b", nm, dif.seg, dif.dig_sel, s, d);
        end
    endtask

    // Counts edges from release: the first edge with rst_n high is edge 1
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            tick();
            chk("in reset", 8'h00, 4'hF);
        end
        rst_n = 1'b1;
        ecount = 0;
    endtask

    task automatic check_frame(input int idx);
        logic [7:0] got[4];
        int cnt[4];
        bit hot_ok;
        int d;
        hot_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got[i] = 'x;
            cnt[i] = 0;
        end
        repeat (4 * SD) begin
            tick();
            d = dif.dig_sel == 4'b1110 ? 0 : dif.dig_sel == 4'b1101 ? 1 :
                dif.dig_sel == 4'b1011 ? 2 : dif.dig_sel == 4'b0111 ? 3 : -1;
            if (d < 0) hot_ok = 1'b0;
            else begin
                got[d] = dif.seg;
                cnt[d]++;
            end
        end
        n_run++;
        if (!hot_ok) begin
            n_fail++;
            $display("FAIL vec%0d one-hot: dig_sel left one-hot-low, expected exactly one low bit", idx);
        end
        for (int k = 0; k < 4; k++) begin
            n_run++;
            if (got[k] !== tv[idx].exp[k*8 +: 8] || cnt[k] != SD) begin
                n_fail++;
                $display("FAIL vec%0d digit%0d: seg=%h held %0d cycles, expected seg=%h held %0d", idx, k, got[k], cnt[k], tv[idx].exp[k*8 +: 8], SD);
            end
        end
    endtask

    initial begin
        tv[0] = '{8'd55,  8'd80,  4'h1, 4'h1, {8'h3F, 8'h7F, 8'h6D, 8'h6D}};
        tv[1] = '{8'd7,   8'd0,   4'h1, 4'h1, {8'h3F, 8'h00, 8'h07, 8'h00}};
        tv[2] = '{8'd0,   8'd9,   4'h1, 4'h1, {8'h6F, 8'h00, 8'h3F, 8'h00}};
        tv[3] = '{8'd150, 8'd255, 4'h1, 4'h1, {8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        tv[4] = '{8'd99,  8'd100, 4'h4, 4'h1, {8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        tv[5] = '{8'd100, 8'd99,  4'h1, 4'h4, {8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        tv[6] = '{8'd10,  8'd10,  4'h1, 4'h8, {8'hBF, 8'h06, 8'h3F, 8'h06}};
        tv[7] = '{8'd42,  8'd31,  4'h8, 4'h3, {8'h06, 8'h4F, 8'hDB, 8'h66}};
        tv[8] = '{8'd63,  8'd27,  4'h0, 4'h4, {8'h07, 8'h5B, 8'h4F, 8'h7D}};
        tv[9] = '{8'd20,  8'd1,   4'h3, 4'hC, {8'h06, 8'h00, 8'h3F, 8'h5B}};

        set_in(8'd55, 8'd80, 4'h1, 4'h1);
        do_reset(3);
        run_to(1);
        chk("release first edge", 8'h00, 4'b1110);
        run_to(10);
        chk("b tens before write", 8'h00, 4'b1011);
        run_to(11);
        chk("b tens after write", 8'h7F, 4'b1011);

        for (int i = 0; i < 10; i++) begin
            set_in(tv[i].a, tv[i].b, tv[i].la, tv[i].lb);
            repeat (24) tick();
            check_frame(i);
        end

        set_in(8'd55, 8'd80, 4'h1, 4'h1);
        do_reset(3);
        run_to(5);
        do_reset(3);
        run_to(1);
        chk("conv reset first edge", 8'h00, 4'b1110);
        run_to(10);
        chk("conv reset regs cleared", 8'h00, 4'b1011);
        run_to(11);
        chk("conv reset first value", 8'h7F, 4'b1011);

        set_in(8'd40, 8'd80, 4'h1, 4'h1);
        do_reset(2);
        run_to(2);
        dif.acount = 8'd39;
        run_to(20);
        chk("latency old value", 8'h66, 4'b1110);
        run_to(21);
        chk("latency new value", 8'h6F, 4'b1101);

        set_in(8'd55, 8'd80, 4'h2, 4'h1);
        do_reset(2);
        run_to(20);
        chk("blink a visible", 8'h6D, 4'b1110);
        run_to(36);
        chk("blink a tens blank", 8'h00, 4'b1110);
        run_to(40);
        chk("blink a ones blank", 8'h00, 4'b1101);
        run_to(44);
        chk("blink b unaffected", 8'h7F, 4'b1011);
        run_to(52);
        chk("blink a still blank", 8'h00, 4'b1110);
        run_to(68);
        chk("blink a visible again", 8'h6D, 4'b1110);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
